// File: rtl/bm_mult_pipe_if.sv
// Operand/result bundle for the block-minifloat multiplier pipeline.
// slave is the multiplier's view, master is the view of whatever drives it.
interface bm_mult_pipe_if #(
  parameter int E     = 3,
  parameter int M     = 4,
  parameter int OE    = E + 1,
  parameter int SB    = 3,
  parameter int LANES = 4
);
  localparam int W  = 1 + E + M;
  localparam int OW = 1 + OE + M;

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*W-1:0]    a;
  logic [LANES*W-1:0]    b;
  logic [SB-1:0]         sb_a;
  logic [SB-1:0]         sb_b;
  logic                  rnd_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OW-1:0]   p;
  logic [SB:0]           sb_p;
  logic [LANES-1:0]      ovf;
  logic [LANES-1:0]      unf;
  logic                  ovf_sticky;
  logic                  sticky_clr;

  modport slave (
    input  in_valid, a, b, sb_a, sb_b, rnd_mode, out_ready, sticky_clr,
    output in_ready, out_valid, p, sb_p, ovf, unf, ovf_sticky
  );

  modport master (
    output in_valid, a, b, sb_a, sb_b, rnd_mode, out_ready, sticky_clr,
    input  in_ready, out_valid, p, sb_p, ovf, unf, ovf_sticky
  );
endinterface

// File: rtl/bm_mult_pipe.sv
// Three-stage, multi-lane block-minifloat multiplier: product, normalise/round,
// then saturate into an OE-bit signed exponent. One global stall enable.
module bm_mult_pipe #(
  parameter int E     = 3,
  parameter int M     = 4,
  parameter int OE    = E + 1,
  parameter int SB    = 3,
  parameter int LANES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  bm_mult_pipe_if.slave  io
);
  localparam int W  = 1 + E + M;
  localparam int OW = 1 + OE + M;
  localparam int PW = 2 * M + 2;
  localparam int XW = E + 3;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** (OE - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(-(2 ** (OE - 1)));

  logic                en;
  logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                rnd1_q, rnd1_d;
  logic [SB:0]         sbs1_q, sbs1_d, sbs2_q, sbs2_d, sbp_q, sbp_d;
  logic                sticky_q, sticky_d;
  logic [LANES*OW-1:0] p_w;
  logic [LANES-1:0]    ovf_w;
  logic [LANES-1:0]    unf_w;

  assign en             = !v3_q || io.out_ready;
  assign io.in_ready    = en;
  assign io.out_valid   = v3_q;
  assign io.p           = p_w;
  assign io.sb_p        = sbp_q;
  assign io.ovf         = ovf_w;
  assign io.unf         = unf_w;
  assign io.ovf_sticky  = sticky_q;

  always_comb begin
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    rnd1_d   = rnd1_q;
    sbs1_d   = sbs1_q;
    sbs2_d   = sbs2_q;
    sbp_d    = sbp_q;
    sticky_d = sticky_q;
    if (en) begin
      v1_d   = io.in_valid;
      v2_d   = v1_q;
      v3_d   = v2_q;
      rnd1_d = io.rnd_mode;
      sbs1_d = {io.sb_a[SB-1], io.sb_a} + {io.sb_b[SB-1], io.sb_b};
      sbs2_d = sbs1_q;
      sbp_d  = sbs2_q;
    end
    // Clear wins over a set arriving in the same cycle.
    if (io.sticky_clr) begin
      sticky_d = 1'b0;
    end else if (v3_q && io.out_ready && |ovf_w) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      rnd1_q   <= 1'b0;
      sbs1_q   <= '0;
      sbs2_q   <= '0;
      sbp_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      rnd1_q   <= rnd1_d;
      sbs1_q   <= sbs1_d;
      sbs2_q   <= sbs2_d;
      sbp_q    <= sbp_d;
      sticky_q <= sticky_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0]           a_l, b_l;
    logic                   sign1_q, sign1_d;
    logic [PW-1:0]          prod1_q, prod1_d;
    logic signed [E:0]      exp1_q, exp1_d;
    logic                   sign2_q, sign2_d;
    logic [M-1:0]           man2_q, man2_d;
    logic signed [XW-1:0]   exp2_q, exp2_d;
    logic [OW-1:0]          p_q, p_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;
    logic                   hi, guard, sticky, round_up;
    logic [M-1:0]           frac;
    logic [M:0]             rsum;

    assign a_l = io.a[gi*W +: W];
    assign b_l = io.b[gi*W +: W];

    always_comb begin
      sign1_d = sign1_q;
      prod1_d = prod1_q;
      exp1_d  = exp1_q;
      sign2_d = sign2_q;
      man2_d  = man2_q;
      exp2_d  = exp2_q;
      p_d     = p_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      // Product of 1.x significands lies in [1,4); the MSB selects the normalising shift.
      hi       = prod1_q[PW-1];
      frac     = hi ? prod1_q[2*M -: M] : prod1_q[2*M-1 -: M];
      guard    = hi ? prod1_q[M] : prod1_q[M-1];
      sticky   = hi ? |prod1_q[M-1:0] : |prod1_q[M-2:0];
      round_up = !rnd1_q && guard && (sticky || frac[0]);
      rsum     = {1'b0, frac} + {{M{1'b0}}, round_up};

      if (en) begin
        sign1_d = a_l[W-1] ^ b_l[W-1];
        prod1_d = {{(M+1){1'b0}}, 1'b1, a_l[M-1:0]} * {{(M+1){1'b0}}, 1'b1, b_l[M-1:0]};
        exp1_d  = {a_l[W-2], a_l[W-2:M]} + {b_l[W-2], b_l[W-2:M]};

        sign2_d = sign1_q;
        man2_d  = rsum[M-1:0];
        exp2_d  = {{(XW-E-1){exp1_q[E]}}, exp1_q} + XW'(hi) + XW'(rsum[M]);

        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (exp2_q > EXP_MAX) begin
          p_d   = {sign2_q, EXP_MAX[OE-1:0], {M{1'b1}}};
          ovf_d = 1'b1;
        end else if (exp2_q < EXP_MIN) begin
          p_d   = {sign2_q, EXP_MIN[OE-1:0], {M{1'b0}}};
          unf_d = 1'b1;
        end else begin
          p_d   = {sign2_q, exp2_q[OE-1:0], man2_q};
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sign1_q <= 1'b0;
        prod1_q <= '0;
        exp1_q  <= '0;
        sign2_q <= 1'b0;
        man2_q  <= '0;
        exp2_q  <= '0;
        p_q     <= '0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        sign1_q <= sign1_d;
        prod1_q <= prod1_d;
        exp1_q  <= exp1_d;
        sign2_q <= sign2_d;
        man2_q  <= man2_d;
        exp2_q  <= exp2_d;
        p_q     <= p_d;
        ovf_q   <= ovf_d;
        unf_q   <= unf_d;
      end
    end

    assign p_w[gi*OW +: OW] = p_q;
    assign ovf_w[gi]        = ovf_q;
    assign unf_w[gi]        = unf_q;
  end
endmodule

// File: doc/bm_mult_pipe.md
Name: bm_mult_pipe

Overview:
- Pipelined, multi-lane block-minifloat (BM) multiplier; successor to the single-lane combinational BM product unit.
- Multiplies LANES pairs of BM operands per beat, each block scaled by a shared bias.
- Normalises the mantissa product, rounds it back to M bits (round-to-nearest-even or truncate), and saturates into a parametrised output exponent width.
- Sits between the BM operand buffers and the accumulator datapath, with valid/ready flow control on both sides.

Parameters:
- E, 3, operand exponent width (signed two's complement field)
- M, 4, operand and result mantissa width (hidden leading 1 is not stored)
- OE, E+1, result exponent width (signed); legal range 2..E+1
- SB, 3, shared-bias width (signed)
- LANES, 4, products per beat

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  LANES*(1+E+M)  operand A; lane i at bits [i*(1+E+M) +: 1+E+M], layout {sign, exp, man}
- b  in  LANES*(1+E+M)  operand B, same layout as a
- sb_a  in  SB  signed shared bias of block A
- sb_b  in  SB  signed shared bias of block B
- rnd_mode  in  1  0 = RNE, 1 = truncate; sampled with the beat
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result beat
- p  out  LANES*(1+OE+M)  products; lane layout {sign, exp[OE], man[M]}
- sb_p  out  SB+1  sb_a+sb_b, sign-extended, exact
- ovf  out  LANES  per-lane exponent saturated high
- unf  out  LANES  per-lane exponent clamped low
- ovf_sticky  out  1  OR of all ovf since the last clear
- sticky_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Operand value: (-1)^s * 1.man * 2^(exp + sb). There is no zero or special encoding.
- Pipeline:
  - S1: register operands, rnd_mode and sb sum; form the (2M+2)-bit product of {1,man} values and the (E+1)-bit signed exponent sum.
  - S2: normalise and round.
  - S3: range-check and saturate; drives the outputs.
- Latency is exactly 3 cycles from acceptance to out_valid when there is no backpressure.
- Handshake:
  - Global stall enable: en = !out_valid || out_ready; in_ready = en.
  - A beat transfers when in_valid && in_ready.
  - While the block is stalled, all stage registers and outputs hold unchanged.
  - Pipeline bubbles propagate as valid=0 stages. Throughput is 1 beat per cycle.
- Per-lane arithmetic:
  - sign = sa ^ sb.
  - If product bit 2M+1 is set, take the fraction from bits [2M:M+1] with guard bit M, sticky = OR of bits [M-1:0], and exp += 1. Otherwise take the fraction from [2M-1:M], guard bit M-1, sticky = OR of bits [M-2:0].
  - RNE: round up when guard && (sticky || lsb). Truncate mode never rounds up.
  - A rounding carry out of the fraction sets the fraction to 0 and adds 1 to exp.
- Range check, with exponent range [-2^(OE-1), 2^(OE-1)-1]:
  - exp above the maximum: output exp = max, man = all ones, sign preserved, ovf=1.
  - exp below the minimum: output exp = min, man = 0, unf=1.
  - ovf and unf are never both set.
- ovf_sticky:
  - Sets on any out-lane ovf in a cycle where out_valid && out_ready.
  - sticky_clr has priority over a same-cycle set.
- Reset (asynchronous, any time including mid-stream):
  - All stage valids go to 0 and all in-flight beats are discarded.
  - out_valid=0, p=0, sb_p=0, ovf=0, unf=0, ovf_sticky=0.
  - in_ready goes high once out_valid is low.
- Outputs are registered; no combinational path from a or b to p.

Test Plan (E=3, M=4, LANES=4, OE=4 unless stated):
- Basic product: lane0 a=0_001_1000 (1.5·2^1), b=0_000_1000 (1.5), all other lanes equal to lane0, sb_a=1, sb_b=-2, rnd_mode=0 -> 3 cycles later p lane0 = 0_0010_0010 (1.125·2^2), sb_p=-1, ovf=unf=0.
- Rounding tie: a=0_000_1000, b=0_000_0001 (1.5×1.0625, fraction 9.5/16):
  - rnd_mode=0 -> man=1010.
  - rnd_mode=1 -> man=1001.
- Rounding carry: a=0_011_0111 (1.4375·2^3), b=0_011_0110 (1.375·2^3), RNE -> 0_0111_0000, no ovf.
- Saturation with OE=3:
  - exp 3 × exp 1, mantissas 0 -> 0_011_1111, ovf=1; ovf_sticky sets and holds until sticky_clr.
  - exp 100 × exp 100 -> 0_100_0000, unf=1.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,... -> all 8 results arrive in order, none dropped or duplicated; p stays stable while out_valid && !out_ready; in_ready equals the stall enable.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid falls immediately; after release no stale beat emerges and the first new beat appears 3 cycles after acceptance.
